c_mult: RTL and testbench

//  Pipelined signed fixed-point complex multiplier: C = A * B, 16-bit Q1.15 operands.

---
 rtl/cmult_pkg.sv | 19 +
 rtl/cmult_scale.sv | 34 +++
 rtl/c_mult.sv | 71 +++++++
 tb/tb_c_mult.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cmult_pkg.sv
// Shared widths, saturation limits and rounding constant for the c_mult complex multiplier.
// The rounding/saturation constants are used only when CMULT_ROUND_EN is defined.
package cmult_pkg;

    localparam int unsigned N      = 16;
    localparam int unsigned SHIFT  = 16;
    localparam int unsigned PROD_W = 2 * N;
    localparam int unsigned SUM_W  = 2 * N + 1;

    localparam logic signed [N-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [N-1:0] SAT_MIN = 16'sh8001;

    typedef logic signed [N-1:0]      word_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    localparam sum_t ROUND_HALF = sum_t'(1) <<< (SHIFT - 1);

endpackage

// File: rtl/cmult_scale.sv
// Scales one full-precision sum down to N bits: floor shift by default,
// round-half-up plus saturation to [SAT_MIN, SAT_MAX] when CMULT_ROUND_EN is defined.
module cmult_scale
    import cmult_pkg::*;
(
    input  sum_t  sum_i,
    output word_t res_o
);

`ifdef CMULT_ROUND_EN
    sum_t rounded;
    sum_t shifted;

    always_comb begin
        rounded = sum_i + ROUND_HALF;
        shifted = rounded >>> SHIFT;
        if (shifted > sum_t'(SAT_MAX)) begin
            res_o = SAT_MAX;
        end else if (shifted < sum_t'(SAT_MIN)) begin
            res_o = SAT_MIN;
        end else begin
            res_o = shifted[N-1:0];
        end
    end
`else
    sum_t shifted;

    always_comb begin
        shifted = sum_i >>> SHIFT;
        res_o   = shifted[N-1:0];
    end
`endif

endmodule

// File: rtl/c_mult.sv
// Two-stage pipelined Q1.15 complex multiplier C = A * B scaled by 2^-SHIFT.
// Optional rounding/saturation selected by CMULT_ROUND_EN (see cmult_scale).
module c_mult
    import cmult_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] Ar,
    input  logic [N-1:0] Ai,
    input  logic [N-1:0] Br,
    input  logic [N-1:0] Bi,
    output logic [N-1:0] Cr,
    output logic [N-1:0] Ci
);

    prod_t ar_x, ai_x, br_x, bi_x;
    prod_t arbr_d, aibi_d, arbi_d, aibr_d;
    prod_t arbr_q, aibi_q, arbi_q, aibr_q;
    sum_t  re_d, im_d;
    word_t cr_d, ci_d;
    word_t cr_q, ci_q;

    // Operands are widened to the product width first so each multiply is exact.
    always_comb begin
        ar_x   = prod_t'($signed(Ar));
        ai_x   = prod_t'($signed(Ai));
        br_x   = prod_t'($signed(Br));
        bi_x   = prod_t'($signed(Bi));
        arbr_d = ar_x * br_x;
        aibi_d = ai_x * bi_x;
        arbi_d = ar_x * bi_x;
        aibr_d = ai_x * br_x;
    end

    always_comb begin
        re_d = sum_t'(arbr_q) - sum_t'(aibi_q);
        im_d = sum_t'(arbi_q) + sum_t'(aibr_q);
    end

    cmult_scale u_scale_re (
        .sum_i (re_d),
        .res_o (cr_d)
    );

    cmult_scale u_scale_im (
        .sum_i (im_d),
        .res_o (ci_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            arbr_q <= '0;
            aibi_q <= '0;
            arbi_q <= '0;
            aibr_q <= '0;
            cr_q   <= '0;
            ci_q   <= '0;
        end else begin
            arbr_q <= arbr_d;
            aibi_q <= aibi_d;
            arbi_q <= arbi_d;
            aibr_q <= aibr_d;
            cr_q   <= cr_d;
            ci_q   <= ci_d;
        end
    end

    assign Cr = cr_q;
    assign Ci = ci_q;

endmodule

// File: tb/tb_c_mult.sv
// Scoreboard bench for c_mult; expected {Cr,Ci} is queued per input edge, popped two edges later.
// Build with or without CMULT_ROUND_EN; the reference model follows the same macro.
module tb_c_mult;

    logic        clk;
    logic        reset;
    logic [15:0] Ar, Ai, Br, Bi;
    logic [15:0] Cr, Ci;

    int unsigned vectors;
    int unsigned miscompares;
    logic [31:0] sb[$];

    c_mult dut (
        .clk   (clk),
        .reset (reset),
        .Ar    (Ar),
        .Ai    (Ai),
        .Br    (Br),
        .Bi    (Bi),
        .Cr    (Cr),
        .Ci    (Ci)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [15:0] ar, input logic [15:0] ai,
                                          input logic [15:0] br, input logic [15:0] bi);
        longint re, im;
        re = longint'($signed(ar)) * longint'($signed(br)) - longint'($signed(ai)) * longint'($signed(bi));
        im = longint'($signed(ar)) * longint'($signed(bi)) + longint'($signed(ai)) * longint'($signed(br));
`ifdef CMULT_ROUND_EN
        re = (re + 32768) >>> 16;
        im = (im + 32768) >>> 16;
        if (re > 32767)  re = 32767;
        if (re < -32767) re = -32767;
        if (im > 32767)  im = 32767;
        if (im < -32767) im = -32767;
`else
        re = re >>> 16;
        im = im >>> 16;
`endif
        return {re[15:0], im[15:0]};
    endfunction

    // Drives one edge and updates the scoreboard; have=1 when an output is due for checking.
    task automatic step(input logic [15:0] ar, input logic [15:0] ai,
                        input logic [15:0] br, input logic [15:0] bi,
                        input logic rst, input logic [31:0] expv,
                        output logic have, output logic [31:0] expected);
        @(negedge clk);
        Ar = ar; Ai = ai; Br = br; Bi = bi; reset = rst;
        @(posedge clk);
        #1;
        have     = 1'b0;
        expected = '0;
        if (!rst) begin
            sb.delete();
            sb.push_back('0);
            have = 1'b1;
        end else begin
            sb.push_back(expv);
            if (sb.size() >= 2) begin
                expected = sb.pop_front();
                have     = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        logic        have;
        logic [31:0] e;
        logic [15:0] r0, r1, r2, r3;
        r0 = 16'($urandom); r1 = 16'($urandom); r2 = 16'($urandom); r3 = 16'($urandom);
        step(r0, r1, r2, r3, 1'b0, '0, have, e);
        vectors++;
        if (!have || {Cr, Ci} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_edge1: got %h, want 00000000", {Cr, Ci});
        end
        step('x, 'x, 'x, 'x, 1'b0, '0, have, e);
        vectors++;
        if (!have || {Cr, Ci} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_edge2_xin: got %h, want 00000000", {Cr, Ci});
        end
        step(r3, r2, r1, r0, 1'b1, model(r3, r2, r1, r0), have, e);
        vectors++;
        if (!have || {Cr, Ci} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_release_hold: got %h, want 00000000", {Cr, Ci});
        end
        step(16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 32'h0, have, e);
        vectors++;
        if (!have || {Cr, Ci} !== e) begin
            miscompares++;
            $display("FAIL reset_first_valid: got %h, want %h", {Cr, Ci}, e);
        end
    endtask

    task automatic test_directed();
        logic        have;
        logic [31:0] e;
        logic [15:0] tv[5][4];
        logic [31:0] te[5];
        tv[0] = '{16'h8000, 16'h0000, 16'h0000, 16'h8000}; te[0] = 32'h0000_4000;
        tv[1] = '{16'h4000, 16'h0000, 16'h4000, 16'h0000}; te[1] = 32'h1000_0000;
        tv[2] = '{16'h0000, 16'h8000, 16'h0000, 16'h8000}; te[2] = 32'hC000_0000;
        // re = 2^31 - 2^15, im = 2^15.
`ifdef CMULT_ROUND_EN
        tv[3] = '{16'h8000, 16'h8000, 16'h8000, 16'h7FFF}; te[3] = 32'h7FFF_0001;
`else
        tv[3] = '{16'h8000, 16'h8000, 16'h8000, 16'h7FFF}; te[3] = 32'h7FFF_0000;
`endif
        tv[4] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000}; te[4] = 32'h0000_7FFF;
`ifndef CMULT_ROUND_EN
        te[4] = 32'h0000_8000;
`endif
        for (int i = 0; i < 6; i++) begin
            if (i < 5) step(tv[i][0], tv[i][1], tv[i][2], tv[i][3], 1'b1, te[i], have, e);
            else       step(16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 32'h0, have, e);
            vectors++;
            if (!have || {Cr, Ci} !== e) begin
                miscompares++;
                $display("FAIL directed_%0d: got %h, want %h", i, {Cr, Ci}, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        have;
        logic [31:0] e;
        logic [15:0] ar, ai, br, bi;
        ar = 16'h8000; ai = 16'h0000; br = 16'h0000; bi = 16'h8000;
        for (int i = 0; i < 65536; i++) begin
            if (i == 20000) begin
                step(ar, ai, br, bi, 1'b0, '0, have, e);
                vectors++;
                if (!have || {Cr, Ci} !== 32'h0) begin
                    miscompares++;
                    $display("FAIL midstream_reset: got %h, want 00000000", {Cr, Ci});
                end
            end else begin
                step(ar, ai, br, bi, 1'b1, model(ar, ai, br, bi), have, e);
                if (have) begin
                    vectors++;
                    if ({Cr, Ci} !== e) begin
                        miscompares++;
                        $display("FAIL sweep_%0d: got %h, want %h", i, {Cr, Ci}, e);
                    end
                end
            end
            ar++; ai++; br++; bi++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b0;
        Ar = '0; Ai = '0; Br = '0; Bi = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
